// File: rtl/oneapi_axi_to_avalon_skid_gasket_if.sv
// Stream bundle between the AXI4-Stream video source and the Avalon-ST sink.
// The gasket uses the slave modport; the source/sink side uses the master modport.
interface oneapi_axi_to_avalon_skid_gasket_if #(
    parameter int BITS_AXI   = 64,
    parameter int TUSER_BITS = 8,
    parameter int BITS_AV    = 96,
    parameter int EMPTY_BITS = 4
);
    logic                  axs_tvalid;
    logic                  axs_tready;
    logic [BITS_AXI-1:0]   axs_tdata;
    logic                  axs_tlast;
    logic [TUSER_BITS-1:0] axs_tuser;
    logic                  aso_valid;
    logic                  aso_ready;
    logic [BITS_AV-1:0]    aso_data;
    logic                  aso_startofpacket;
    logic                  aso_endofpacket;
    logic [EMPTY_BITS-1:0] aso_empty;

    modport master (
        output axs_tvalid, axs_tdata, axs_tlast, axs_tuser, aso_ready,
        input  axs_tready, aso_valid, aso_data, aso_startofpacket, aso_endofpacket, aso_empty
    );

    modport slave (
        input  axs_tvalid, axs_tdata, axs_tlast, axs_tuser, aso_ready,
        output axs_tready, aso_valid, aso_data, aso_startofpacket, aso_endofpacket, aso_empty
    );
endinterface

// File: rtl/oneapi_axi_to_avalon_skid_gasket.sv
// AXI4-Stream packed video -> Avalon-ST unpacked pixels through a 2-entry skid buffer.
// Optional framing checker compiled in with GASKET_FRAMING_CHECK_EN.
module oneapi_axi_to_avalon_skid_gasket #(
    parameter int PARALLEL_PIXELS      = 2,
    parameter int BITS_PER_CHANNEL     = 10,
    parameter int CHANNELS             = 3,
    parameter int BITS_PER_CHANNEL_AV  = 1 << $clog2(BITS_PER_CHANNEL),
    parameter int BITS_PER_PIXEL_AV    = BITS_PER_CHANNEL_AV * CHANNELS,
    parameter int BITS_AV              = BITS_PER_PIXEL_AV * PARALLEL_PIXELS,
    parameter int EMPTY_BITS           = $clog2(BITS_AV / 8),
    parameter int BITS_PER_CHANNEL_AXI = BITS_PER_CHANNEL,
    parameter int BITS_PER_PIXEL_AXI   = 8 * ((CHANNELS * BITS_PER_CHANNEL_AXI + 7) / 8),
    parameter int BITS_AXI             = BITS_PER_PIXEL_AXI * PARALLEL_PIXELS,
    parameter int TUSER_BITS           = (BITS_AXI + 7) / 8
) (
    input  logic csi_clk,
    input  logic rsi_reset_n,
    oneapi_axi_to_avalon_skid_gasket_if.slave bus,
    output logic coe_framing_err
);
    localparam int PAD_BITS = BITS_PER_PIXEL_AXI - CHANNELS * BITS_PER_CHANNEL_AXI;
    localparam int PAD_W    = (PAD_BITS > 0) ? PAD_BITS : 1;

    logic [BITS_AV-1:0]             unpacked;
    logic [PARALLEL_PIXELS*PAD_W-1:0] unused_pad;
    logic [TUSER_BITS-1:1]          unused_tuser;

    for (genvar gi = 0; gi < PARALLEL_PIXELS; gi++) begin : g_pix
        for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_ch
            assign unpacked[gi*BITS_PER_PIXEL_AV + gc*BITS_PER_CHANNEL_AV +: BITS_PER_CHANNEL_AV] =
                BITS_PER_CHANNEL_AV'(bus.axs_tdata[gi*BITS_PER_PIXEL_AXI + gc*BITS_PER_CHANNEL_AXI +: BITS_PER_CHANNEL_AXI]);
        end
        if (PAD_BITS > 0) begin : g_pad
            assign unused_pad[gi*PAD_W +: PAD_W] =
                bus.axs_tdata[gi*BITS_PER_PIXEL_AXI + CHANNELS*BITS_PER_CHANNEL_AXI +: PAD_W];
        end else begin : g_nopad
            assign unused_pad[gi*PAD_W +: PAD_W] = '0;
        end
    end
    assign unused_tuser = bus.axs_tuser[TUSER_BITS-1:1];

    logic               out_valid_q, out_valid_d;
    logic [BITS_AV-1:0] out_data_q,  out_data_d;
    logic               out_sop_q,   out_sop_d;
    logic               out_eop_q,   out_eop_d;
    logic               skid_valid_q, skid_valid_d;
    logic [BITS_AV-1:0] skid_data_q,  skid_data_d;
    logic               skid_sop_q,   skid_sop_d;
    logic               skid_eop_q,   skid_eop_d;
    logic               tready_q,     tready_d;
    logic               accept;
    logic               forward;

    assign accept = bus.axs_tvalid && tready_q;

`ifdef GASKET_FRAMING_CHECK_EN
    typedef enum logic {S_IDLE, S_IN_PKT} state_t;
    state_t state_q;
    logic   err_q;

    // A beat outside a packet is only legal if it opens one.
    assign forward = bus.axs_tuser[0] || (state_q == S_IN_PKT);

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else if (accept) begin
            if (bus.axs_tuser[0]) begin
                if (state_q == S_IN_PKT) err_q <= 1'b1;
                state_q <= bus.axs_tlast ? S_IDLE : S_IN_PKT;
            end else if (state_q == S_IDLE) begin
                err_q <= 1'b1;
            end else if (bus.axs_tlast) begin
                state_q <= S_IDLE;
            end
        end
    end
    assign coe_framing_err = err_q;
`else
    assign forward         = 1'b1;
    assign coe_framing_err = 1'b0;
`endif

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sop_d    = out_sop_q;
        out_eop_d    = out_eop_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_sop_d   = skid_sop_q;
        skid_eop_d   = skid_eop_q;
        if (!out_valid_q || bus.aso_ready) begin
            // SKID always has priority; no accept can coincide because tready is low while it is full.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_sop_d    = skid_sop_q;
                out_eop_d    = skid_eop_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept && forward;
                if (accept && forward) begin
                    out_data_d = unpacked;
                    out_sop_d  = bus.axs_tuser[0];
                    out_eop_d  = bus.axs_tlast;
                end
            end
        end else if (accept && forward) begin
            skid_valid_d = 1'b1;
            skid_data_d  = unpacked;
            skid_sop_d   = bus.axs_tuser[0];
            skid_eop_d   = bus.axs_tlast;
        end
        tready_d = !skid_valid_d;
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_sop_q   <= 1'b0;
            skid_eop_q   <= 1'b0;
            tready_q     <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_sop_q   <= skid_sop_d;
            skid_eop_q   <= skid_eop_d;
            tready_q     <= tready_d;
        end
    end

    assign bus.axs_tready        = tready_q;
    assign bus.aso_valid         = out_valid_q;
    assign bus.aso_data          = out_data_q;
    assign bus.aso_startofpacket = out_sop_q;
    assign bus.aso_endofpacket   = out_eop_q;
    assign bus.aso_empty         = '0;
endmodule

// File: tb/tb_oneapi_axi_to_avalon_skid_gasket.sv
// Directed bench for the AXI->Avalon skid gasket; expected values are hand-computed
// or built from a per-channel value table packed/unpacked independently.
module tb_oneapi_axi_to_avalon_skid_gasket;
    logic csi_clk = 1'b0;
    logic rsi_reset_n = 1'b0;
    logic coe_framing_err;
    int   checks = 0;
    int   errors = 0;

    oneapi_axi_to_avalon_skid_gasket_if bus ();

    oneapi_axi_to_avalon_skid_gasket dut (
        .csi_clk         (csi_clk),
        .rsi_reset_n     (rsi_reset_n),
        .bus             (bus),
        .coe_framing_err (coe_framing_err)
    );

    always #5 csi_clk = ~csi_clk;

    function automatic logic [9:0] chv(input int s, input int p, input int c);
        return 10'((s * 97 + p * 41 + c * 13 + 5) & 1023);
    endfunction

    function automatic logic [63:0] pack_axi(input int s);
        logic [63:0] r;
        r = '0;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 3; c++) r[p*32 + c*10 +: 10] = chv(s, p, c);
            r[p*32 + 30 +: 2] = 2'b11;
        end
        return r;
    endfunction

    function automatic logic [95:0] exp_av(input int s);
        logic [95:0] r;
        r = '0;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 3; c++) r[p*48 + c*16 +: 16] = {6'b0, chv(s, p, c)};
        return r;
    endfunction

    task automatic drive_beat(input int s, input logic u, input logic l, input logic v);
        bus.axs_tvalid = v;
        bus.axs_tdata  = pack_axi(s);
        bus.axs_tuser  = {7'b1010101, u};
        bus.axs_tlast  = l;
    endtask

    task automatic test_reset();
        bus.axs_tvalid = 1'b0;
        bus.axs_tdata  = '0;
        bus.axs_tuser  = '0;
        bus.axs_tlast  = 1'b0;
        bus.aso_ready  = 1'b0;
        #12;
        checks++; if (bus.axs_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b want 0", bus.axs_tready); end
        checks++; if (bus.aso_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.aso_valid); end
        checks++; if (bus.aso_data !== 96'h0) begin errors++; $display("FAIL rst_data got %h want 0", bus.aso_data); end
        checks++; if ({bus.aso_startofpacket, bus.aso_endofpacket, bus.aso_empty} !== 6'b0) begin
            errors++; $display("FAIL rst_flags got %b want 000000", {bus.aso_startofpacket, bus.aso_endofpacket, bus.aso_empty}); end
        checks++; if (coe_framing_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", coe_framing_err); end
        @(negedge csi_clk);
        rsi_reset_n = 1'b1;
        #1;
        checks++; if (bus.axs_tready !== 1'b0) begin errors++; $display("FAIL rel_tready_early got %b want 0", bus.axs_tready); end
        @(posedge csi_clk); #1;
        checks++; if (bus.axs_tready !== 1'b1) begin errors++; $display("FAIL rel_tready got %b want 1", bus.axs_tready); end
        checks++; if (bus.aso_valid !== 1'b0) begin errors++; $display("FAIL rel_valid got %b want 0", bus.aso_valid); end
        $display("reset: tready=%b valid=%b", bus.axs_tready, bus.aso_valid);
    endtask

    task automatic test_single();
        bus.aso_ready  = 1'b1;
        bus.axs_tvalid = 1'b1;
        bus.axs_tdata  = 64'h02308821_01304811;
        bus.axs_tuser  = 8'h01;
        bus.axs_tlast  = 1'b0;
        @(posedge csi_clk); #1;
        bus.axs_tvalid = 1'b0;
        checks++; if (bus.aso_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.aso_valid); end
        checks++; if (bus.aso_data !== 96'h0023_0022_0021_0013_0012_0011) begin
            errors++; $display("FAIL single_data got %h want 002300220021001300120011", bus.aso_data); end
        checks++; if ({bus.aso_startofpacket, bus.aso_endofpacket} !== 2'b10) begin
            errors++; $display("FAIL single_sop_eop got %b want 10", {bus.aso_startofpacket, bus.aso_endofpacket}); end
        checks++; if (bus.aso_empty !== 4'h0) begin errors++; $display("FAIL single_empty got %h want 0", bus.aso_empty); end
        $display("single: data=%h sop=%b eop=%b", bus.aso_data, bus.aso_startofpacket, bus.aso_endofpacket);
        @(posedge csi_clk); #1;
        checks++; if (bus.aso_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", bus.aso_valid); end
    endtask

    task automatic test_pad();
        bus.axs_tvalid = 1'b1;
        bus.axs_tdata  = 64'hFFFFFFFF_FFFFFFFF;
        bus.axs_tuser  = 8'hFE;
        bus.axs_tlast  = 1'b1;
        @(posedge csi_clk); #1;
        bus.axs_tvalid = 1'b0;
        checks++; if (bus.aso_data !== 96'h03FF_03FF_03FF_03FF_03FF_03FF) begin
            errors++; $display("FAIL pad_data got %h want 03ff03ff03ff03ff03ff03ff", bus.aso_data); end
        checks++; if ({bus.aso_valid, bus.aso_startofpacket, bus.aso_endofpacket} !== 3'b101) begin
            errors++; $display("FAIL pad_flags got %b want 101", {bus.aso_valid, bus.aso_startofpacket, bus.aso_endofpacket}); end
        $display("pad: data=%h", bus.aso_data);
        @(posedge csi_clk); #1;
    endtask

    task automatic test_backpressure();
        int src = 0;
        int snk = 0;
        logic stall = 1'b0;
        logic [95:0] held = '0;
        for (int c = 1; c <= 14; c++) begin
            checks++; if (bus.axs_tready !== ((c >= 3 && c <= 7) ? 1'b0 : 1'b1)) begin
                errors++; $display("FAIL bp_tready cycle %0d got %b want %b", c, bus.axs_tready, (c >= 3 && c <= 7) ? 1'b0 : 1'b1); end
            if (stall) begin
                checks++; if (bus.aso_valid !== 1'b1 || bus.aso_data !== held) begin
                    errors++; $display("FAIL bp_hold cycle %0d got %b/%h want 1/%h", c, bus.aso_valid, bus.aso_data, held); end
            end
            bus.aso_ready = !(c >= 2 && c <= 6);
            drive_beat(40 + src, src == 0, src == 4, src < 5);
            if (bus.axs_tvalid && bus.axs_tready) src++;
            if (bus.aso_valid && bus.aso_ready) begin
                checks++; if (snk >= 5 || bus.aso_data !== exp_av(40 + snk)) begin
                    errors++; $display("FAIL bp_data beat %0d got %h want %h", snk, bus.aso_data, exp_av(40 + snk)); end
                $display("backpressure: cycle %0d beat %0d data=%h", c, snk, bus.aso_data);
                snk++;
            end
            stall = bus.aso_valid && !bus.aso_ready;
            held  = bus.aso_data;
            @(posedge csi_clk); #1;
        end
        bus.axs_tvalid = 1'b0;
        checks++; if (snk != 5) begin errors++; $display("FAIL bp_count got %0d want 5", snk); end
    endtask

    task automatic test_packet();
        int src = 0;
        int snk = 0;
        int sops = 0;
        int eops = 0;
        for (int c = 1; c <= 20; c++) begin
            bus.aso_ready = c[0];
            drive_beat(10 + src, src == 0, src == 3, src < 4);
            if (bus.axs_tvalid && bus.axs_tready) src++;
            if (bus.aso_valid && bus.aso_ready) begin
                checks++; if (snk >= 4 || bus.aso_data !== exp_av(10 + snk) ||
                              bus.aso_startofpacket !== (snk == 0) || bus.aso_endofpacket !== (snk == 3)) begin
                    errors++; $display("FAIL pkt_beat %0d got %h sop=%b eop=%b want %h sop=%b eop=%b", snk, bus.aso_data,
                        bus.aso_startofpacket, bus.aso_endofpacket, exp_av(10 + snk), snk == 0, snk == 3); end
                sops += int'(bus.aso_startofpacket);
                eops += int'(bus.aso_endofpacket);
                $display("packet: cycle %0d beat %0d sop=%b eop=%b", c, snk, bus.aso_startofpacket, bus.aso_endofpacket);
                snk++;
            end
            @(posedge csi_clk); #1;
        end
        bus.axs_tvalid = 1'b0;
        bus.aso_ready  = 1'b1;
        checks++; if (snk != 4 || sops != 1 || eops != 1) begin
            errors++; $display("FAIL pkt_count got beats=%0d sop=%0d eop=%0d want 4/1/1", snk, sops, eops); end
    endtask

    task automatic test_midstream_reset();
        bus.aso_ready = 1'b0;
        drive_beat(50, 1'b1, 1'b0, 1'b1);
        @(posedge csi_clk); #1;
        drive_beat(51, 1'b0, 1'b1, 1'b1);
        @(posedge csi_clk); #1;
        bus.axs_tvalid = 1'b0;
        checks++; if ({bus.aso_valid, bus.axs_tready} !== 2'b10) begin
            errors++; $display("FAIL mid_full got valid/tready %b want 10", {bus.aso_valid, bus.axs_tready}); end
        #2 rsi_reset_n = 1'b0;
        #1;
        checks++; if ({bus.aso_valid, bus.axs_tready, bus.aso_startofpacket} !== 3'b000 || bus.aso_data !== 96'h0) begin
            errors++; $display("FAIL mid_flush got valid/tready/sop %b data %h want 000 0",
                {bus.aso_valid, bus.axs_tready, bus.aso_startofpacket}, bus.aso_data); end
        @(negedge csi_clk);
        rsi_reset_n = 1'b1;
        bus.aso_ready = 1'b1;
        @(posedge csi_clk); #1;
        checks++; if ({bus.aso_valid, bus.axs_tready} !== 2'b01) begin
            errors++; $display("FAIL mid_release got valid/tready %b want 01", {bus.aso_valid, bus.axs_tready}); end
        $display("midstream reset: valid=%b tready=%b", bus.aso_valid, bus.axs_tready);
    endtask

    task automatic test_framing();
        int src = 0;
        int snk = 0;
        int exp_n;
        int exp_s[2];
        logic exp_err;
`ifdef GASKET_FRAMING_CHECK_EN
        exp_n = 1; exp_s[0] = 61; exp_s[1] = 61; exp_err = 1'b1;
`else
        exp_n = 2; exp_s[0] = 60; exp_s[1] = 61; exp_err = 1'b0;
`endif
        checks++; if (coe_framing_err !== 1'b0) begin errors++; $display("FAIL frm_err_init got %b want 0", coe_framing_err); end
        bus.aso_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            drive_beat(60 + src, src == 1, src == 1, src < 2);
            if (bus.axs_tvalid && bus.axs_tready) src++;
            if (bus.aso_valid) begin
                checks++; if (snk >= exp_n || bus.aso_data !== exp_av(exp_s[snk])) begin
                    errors++; $display("FAIL frm_beat %0d got %h want %h (expected %0d beats)", snk, bus.aso_data,
                        exp_av(exp_s[snk < 2 ? snk : 1]), exp_n); end
                $display("framing: cycle %0d beat %0d data=%h", c, snk, bus.aso_data);
                snk++;
            end
            @(posedge csi_clk); #1;
        end
        bus.axs_tvalid = 1'b0;
        checks++; if (snk != exp_n) begin errors++; $display("FAIL frm_count got %0d want %0d", snk, exp_n); end
        checks++; if (coe_framing_err !== exp_err) begin
            errors++; $display("FAIL frm_err got %b want %b", coe_framing_err, exp_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pad();
        test_backpressure();
        test_packet();
        test_midstream_reset();
        test_framing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
